uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit-side counterpart of the UART receive path.
- Pops bytes from an 8-bit first-word-fall-through transmit FIFO (same interface as rx_fifo: r_enable, r_data, empty) and serializes each byte onto a single line.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1). The line idles high.
- Sits between the tx FIFO and the chip's serial output pin.

Parameters:
- BIT_PERIOD, 10, clock cycles per serial bit; legal range 2..1023.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic rises on its positive edge.
- n_rst  input  1  synchronous active-low reset, sampled on rising clk.
- fifo_empty  input  1  tx FIFO empty flag.
- fifo_data  input  8  tx FIFO head byte; valid whenever fifo_empty=0 (first-word-fall-through).
- fifo_r_enable  output  1  single-cycle pop strobe to the tx FIFO.
- tx_out  output  1  serial line, registered.
- tx_busy  output  1  high while a frame is being loaded or sent.
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset: on any rising edge with n_rst=0, all state goes to its reset value:
  - state = IDLE, bit counter = 0, period counter = 0, shift register = 0.
  - tx_out = 1, tx_busy = 0, fifo_r_enable = 0, frame_done = 0.
- Reset applies mid-frame: the frame is aborted, tx_out is 1 after that edge, and the popped byte is discarded (not re-read).
- States are IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx_out = 1.
  - fifo_empty=0 sampled at an edge → next state LOAD.
- LOAD (exactly 1 cycle):
  - fifo_r_enable = 1 (combinational decode of state, high only in LOAD).
  - The shift register captures fifo_data[DATA_BITS-1:0] on the edge ending LOAD.
  - Next state START.
- START:
  - tx_out = 0 for BIT_PERIOD cycles.
  - Period counter counts 0..BIT_PERIOD-1; at terminal count → DATA with bit counter = 0.
- DATA:
  - tx_out = shift register bit 0.
  - At each period terminal count: shift right by one and increment the bit counter.
  - After DATA_BITS bits → STOP.
- STOP:
  - tx_out = 1 for BIT_PERIOD cycles.
  - frame_done = 1 during the final cycle of the period.
  - At terminal count: fifo_empty=0 → LOAD (back-to-back; no idle bit beyond the stop bit); fifo_empty=1 → IDLE.
- tx_out is driven from a flop; the value for each state above appears on the cycle after the state is entered.
- Latency: fifo_empty falls before edge k → LOAD during cycle k..k+1 → tx_out = 0 from edge k+2.
- Frame length on the line: (DATA_BITS+2)*BIT_PERIOD cycles. Back-to-back frames are separated by exactly one LOAD cycle of extra high level.
- tx_busy = (state != IDLE).
- fifo_empty changes during START/DATA/STOP are ignored. No FIFO pop occurs outside LOAD, so the FIFO is never read while empty.
- Counter widths:
  - Period counter: clog2(BIT_PERIOD) bits.
  - Bit counter: clog2(DATA_BITS+1) bits.
  - Neither counter passes its terminal value; both reset to 0 on every state change.
- Bits of fifo_data above DATA_BITS-1 are ignored.

Test Plan:
- Reset/idle: hold n_rst=0 for 2 cycles with fifo_empty=1 → tx_out=1, tx_busy=0, fifo_r_enable=0, frame_done=0. Release reset, keep empty for 50 cycles → outputs unchanged, no pop.
- Single byte, defaults (BIT_PERIOD=10, DATA_BITS=8): present 0xA5 with fifo_empty=0; deassert empty after the pop.
  - Exactly one fifo_r_enable pulse.
  - tx_out = 0 for 10 cycles, then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles.
  - frame_done pulses once, on stop-bit cycle 10.
  - Return to IDLE with tx_busy=0 at 101 cycles after LOAD.
- Back-to-back: FIFO holds 0x00 then 0xFF.
  - Two pops, 101 cycles apart.
  - Line: start, eight 0s, stop (10 cycles) plus 1 LOAD-cycle high, then start, eight 1s, stop.
  - tx_busy stays 1 throughout both frames.
- Mid-frame reset: during DATA bit 3 of 0x3C, pulse n_rst=0 for 1 cycle with fifo_empty=1.
  - tx_out=1 and tx_busy=0 after that edge.
  - No frame_done pulse.
  - After reset, 30 idle cycles with no pop.
- Pop discipline: random fifo_empty toggling over 1000 frames of random data.
  - Pop count equals frame_done count.
  - No pop while fifo_empty=1.
  - Every received byte decoded by a bench-side UART model matches the FIFO order.
- Parameter corners: BIT_PERIOD=2 with DATA_BITS=5, byte 0x15 → 14-cycle frame 0,1,0,1,0,1,1 (2 cycles per bit); bits 7:5 of fifo_data are ignored.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit half of the UART. Pops bytes from a first-word-fall-through tx
// FIFO and shifts each one out as a frame: one start bit (0), DATA_BITS data
// bits LSB first, one stop bit (1). The line idles high. When the FIFO still
// holds data at the end of a stop bit, the next frame follows after a single
// LOAD cycle of extra high level.
//
// Parameters:
//   BIT_PERIOD  clock cycles per serial bit (2..1023)
//   DATA_BITS   data bits per frame (5..8)
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          synchronous active-low reset
//   fifo_empty     tx FIFO empty flag
//   fifo_data      tx FIFO head byte, valid while fifo_empty = 0
//   fifo_r_enable  one-cycle pop strobe, high only in LOAD
//   tx_out         registered serial line
//   tx_busy        high while a frame is being loaded or sent
//   frame_done     one-cycle pulse on the last line cycle of each stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_r_enable,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int PW = $clog2(BIT_PERIOD);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    logic [PW-1:0]          period_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   period_last;
    logic                   line_bit;

    // Bits of fifo_data above DATA_BITS-1 carry no meaning for this frame
    // width; folding them here keeps them visibly accounted for.
    logic unused_fifo_bits;
    assign unused_fifo_bits = ^fifo_data;

    assign period_last   = (period_cnt == PERIOD_LAST);
    assign fifo_r_enable = (state == LOAD);
    assign tx_busy       = (state != IDLE);

    // Line level belonging to the current state; tx_out registers it, so the
    // pin shows each state's level one cycle after the state is entered.
    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_reg[0];
            default: line_bit = 1'b1;
        endcase
    end

    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; blocking '=' would let later statements
    // see already-updated state and break the one-cycle relationships.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tx_out     <= line_bit;
            // Registered alongside tx_out so the pulse lines up with the
            // final line cycle of the stop bit rather than the state's.
            frame_done <= (state == STOP) && period_last;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    shift_reg  <= fifo_data[DATA_BITS-1:0];
                    period_cnt <= '0;
                    state      <= START;
                end

                START: begin
                    if (period_last) begin
                        period_cnt <= '0;
                        bit_cnt    <= '0;
                        state      <= DATA;
                    end else begin
                        period_cnt <= period_cnt + PW'(1);
                    end
                end

                DATA: begin
                    if (period_last) begin
                        period_cnt <= '0;
                        shift_reg  <= shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        period_cnt <= period_cnt + PW'(1);
                    end
                end

                STOP: begin
                    if (period_last) begin
                        period_cnt <= '0;
                        // Back-to-back frames go straight to LOAD with no
                        // idle bit beyond the stop bit.
                        state      <= fifo_empty ? IDLE : LOAD;
                    end else begin
                        period_cnt <= period_cnt + PW'(1);
                    end
                end

                default: begin
                    period_cnt <= '0;
                    bit_cnt    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Two serializers run side by side: A with the default parameters
// (BIT_PERIOD=10, DATA_BITS=8) and B at the small corner (BIT_PERIOD=2,
// DATA_BITS=5). Each is fed from a bench-side FIFO. A frame-level reference
// predicts, per cycle, when a pop must happen and what the line, busy flag
// and frame_done must show, purely from pop times and frame arithmetic.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic            tb_clk = 1'b0;
    logic            n_rst;
    logic [1:0]      fifo_empty;
    logic [1:0][7:0] fifo_data;
    wire  [1:0]      r_en;
    wire  [1:0]      tx;
    wire  [1:0]      busy;
    wire  [1:0]      fdone;

    always #5 tb_clk = ~tb_clk;

    uart_tx_serializer #(.BIT_PERIOD(10), .DATA_BITS(8)) dut_a (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty[0]),
        .fifo_data     (fifo_data[0]),
        .fifo_r_enable (r_en[0]),
        .tx_out        (tx[0]),
        .tx_busy       (busy[0]),
        .frame_done    (fdone[0])
    );

    uart_tx_serializer #(.BIT_PERIOD(2), .DATA_BITS(5)) dut_b (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty[1]),
        .fifo_data     (fifo_data[1]),
        .fifo_r_enable (r_en[1]),
        .tx_out        (tx[1]),
        .tx_busy       (busy[1]),
        .frame_done    (fdone[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Bench FIFOs: storage plus read/write pointers per instance.
    logic [7:0] fmem [2][4096];
    int wr [2];
    int rd [2];

    // Observed activity.
    int pops [2];
    int fds  [2];
    int last_pop [2];
    int prev_pop [2];
    int last_fd  [2];
    bit pop_pending [2];

    // Reference model state.
    int         m_p    [2];   // cycle index of the most recent expected pop
    int         m_free [2];   // first cycle a new pop may occur
    bit         m_have [2];
    logic [7:0] m_byte [2];
    bit         prev_empty [2];
    bit         rst_seen;     // n_rst was low at the edge before this sample

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int bp_of(input int k);
        return (k == 0) ? 10 : 2;
    endfunction

    function automatic int db_of(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][wr[k]] = b;
        wr[k]++;
    endtask

    task automatic drive_fifo();
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = (rd[k] >= wr[k]);
            fifo_data[k]  = fifo_empty[k] ? 8'($urandom) : fmem[k][rd[k]];
        end
    endtask

    // Called once per cycle, away from the clock edge.
    task automatic model_cycle(input int k);
        int    bp, db, len, t, kb;
        logic  e_tx, e_fd, e_pop, e_busy;
        string nm;
        bp  = bp_of(k);
        db  = db_of(k);
        len = (db + 2) * bp;
        nm  = (k == 0) ? "A" : "B";
        if (rst_seen) begin
            e_tx   = 1'b1;
            e_fd   = 1'b0;
            e_pop  = 1'b0;
            e_busy = 1'b0;
            m_have[k] = 1'b0;
            m_free[k] = cyc + 1;
        end else begin
            // Frame on the line spans pop+2 .. pop+len+1.
            e_tx = 1'b1;
            if (m_have[k] && cyc >= m_p[k] + 2 && cyc <= m_p[k] + len + 1) begin
                t  = cyc - m_p[k] - 2;
                kb = t / bp;
                if (kb == 0)
                    e_tx = 1'b0;
                else if (kb <= db)
                    e_tx = m_byte[k][kb-1];
            end
            e_fd  = m_have[k] && (cyc == m_p[k] + len + 1);
            e_pop = (cyc >= m_free[k]) && !prev_empty[k];
            if (e_pop) begin
                m_p[k]    = cyc;
                m_byte[k] = fmem[k][rd[k]];
                m_have[k] = 1'b1;
                m_free[k] = cyc + len + 1;
            end
            e_busy = m_have[k] && cyc >= m_p[k] && cyc <= m_p[k] + len;
        end
        check({nm, ".tx_out"},     tx[k],    e_tx);
        check({nm, ".frame_done"}, fdone[k], e_fd);
        check({nm, ".pop"},        r_en[k],  e_pop);
        check({nm, ".busy"},       busy[k],  e_busy);
        check({nm, ".pop_empty"},  r_en[k] & fifo_empty[k], 1'b0);
        if (r_en[k]) begin
            pops[k]++;
            prev_pop[k] = last_pop[k];
            last_pop[k] = cyc;
        end
        if (fdone[k]) begin
            fds[k]++;
            last_fd[k] = cyc;
        end
        pop_pending[k] = r_en[k];
        prev_empty[k]  = fifo_empty[k];
    endtask

    task automatic step();
        drive_fifo();
        @(negedge tb_clk);
        cyc++;
        for (int k = 0; k < 2; k++) model_cycle(k);
        @(posedge tb_clk);
        rst_seen = !n_rst;
        #1;
        for (int k = 0; k < 2; k++)
            if (pop_pending[k] && rd[k] < wr[k]) rd[k]++;
    endtask

    initial begin
        int         w;
        int         fds_before;
        int         pushed;
        int         budget;
        logic [13:0] line;

        n_rst    = 1'b0;
        rst_seen = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr[k] = 0; rd[k] = 0; pops[k] = 0; fds[k] = 0;
            last_pop[k] = 0; prev_pop[k] = 0; last_fd[k] = 0;
            m_p[k] = 0; m_free[k] = 0; m_have[k] = 1'b0; m_byte[k] = '0;
            prev_empty[k] = 1'b1; pop_pending[k] = 1'b0;
        end

        // Reset and idle.
        repeat (2) step();
        check("rst_tx_out",  tx[0],    1'b1);
        check("rst_busy",    busy[0],  1'b0);
        check("rst_pop",     r_en[0],  1'b0);
        check("rst_fdone",   fdone[0], 1'b0);
        n_rst = 1'b1;
        repeat (50) step();
        check("idle_no_pop", pops[0] + pops[1], 0);
        check("idle_tx_out", tx[0], 1'b1);

        // Single byte 0xA5.
        push(0, 8'hA5);
        repeat (120) step();
        check("a5_pops",     pops[0], 1);
        check("a5_fdones",   fds[0],  1);
        check("a5_fd_delay", last_fd[0] - last_pop[0], 101);
        check("a5_idle",     busy[0], 1'b0);

        // Back-to-back 0x00 then 0xFF.
        push(0, 8'h00);
        push(0, 8'hFF);
        repeat (230) step();
        check("b2b_pops",   pops[0], 3);
        check("b2b_gap",    last_pop[0] - prev_pop[0], 101);
        check("b2b_fdones", fds[0], 3);

        // Mid-frame reset during DATA bit 3 of 0x3C.
        push(0, 8'h3C);
        w = 0;
        while (pops[0] == 3 && w < 20) begin
            step();
            w++;
        end
        check("mr_pop_seen", pops[0], 4);
        repeat (44) step();
        fds_before = fds[0];
        n_rst = 1'b0;
        step();
        check("mr_tx_out", tx[0],   1'b1);
        check("mr_busy",   busy[0], 1'b0);
        n_rst = 1'b1;
        repeat (30) step();
        check("mr_no_fdone", fds[0],  fds_before);
        check("mr_no_pop",   pops[0], 4);

        // Corner instance: 0xF5 carries 0x15 in its low five bits.
        push(1, 8'hF5);
        w = 0;
        while (pops[1] == 0 && w < 10) begin
            step();
            w++;
        end
        check("b_pop_seen", pops[1], 1);
        step();
        for (int i = 0; i < 14; i++) begin
            line[13-i] = tx[1];
            step();
        end
        check("b_frame_bits", {18'd0, line}, {18'd0, 14'b00110011001111});
        repeat (5) step();
        check("b_fd_delay", last_fd[1] - last_pop[1], 15);

        // Random traffic on the corner instance: 1000 frames.
        pushed = 0;
        budget = 0;
        while ((pushed < 1000 || rd[1] < wr[1] || busy[1]) && budget < 40000) begin
            if (pushed < 1000 && $urandom_range(0, 31) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    if (pushed < 1000) begin
                        push(1, 8'($urandom));
                        pushed++;
                    end
                end
            end
            step();
            budget++;
        end
        repeat (5) step();
        check("rnd_in_budget", budget < 40000, 1'b1);
        check("rnd_pops",      pops[1], 1001);
        check("rnd_fd_eq_pop", fds[1],  pops[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
